// File: rtl/screen_ram_filler.sv
// Screen RAM port-B filler: writes one pattern word per clock into every RAM word,
// after reset release or on request, and hands port B to the VGA read path while idle.
module screen_ram_filler #(
   parameter int                    DATA_WIDTH         = 16,
   parameter int                    RAM_REGISTER_COUNT = 1024,
   parameter int                    ADDR_WIDTH         = $clog2(RAM_REGISTER_COUNT),
   parameter int                    FILL_ON_RESET      = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_FILL_VALUE   = '0
) (
   input  logic                  CLK_50,
   input  logic                  resetN,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] fill_value,
   input  logic [ADDR_WIDTH-1:0] vga_address,
   output logic [ADDR_WIDTH-1:0] ram_address_b,
   output logic [DATA_WIDTH-1:0] ram_data_b,
   output logic                  ram_wren_b,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_hold
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_IDLE = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR      = ADDR_WIDTH'(1);
   localparam logic                  BUSY_AT_RESET = (FILL_ON_RESET != 0);

   logic [1:0]            state_q,   state_d;
   logic [ADDR_WIDTH-1:0] counter_q, counter_d;
   logic [DATA_WIDTH-1:0] fill_q,    fill_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;

   // Next-state logic for the fill sequencer
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      fill_d    = fill_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (BUSY_AT_RESET) begin
               state_d = ST_FILL;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         ST_FILL: begin
            if (counter_q == LAST_ADDR) begin
               state_d   = ST_IDLE;
               counter_d = '0;
               done_d    = 1'b1;
               // a held start is taken on the very next edge, so hold stays asserted
               busy_d    = start;
            end else begin
               counter_d = counter_q + ONE_ADDR;
               busy_d    = 1'b1;
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FILL;
               fill_d    = fill_value;
               counter_d = '0;
               busy_d    = 1'b1;
            end else begin
               busy_d    = 1'b0;
            end
         end
         default: begin
            state_d   = ST_INIT;
            counter_d = '0;
            fill_d    = RESET_FILL_VALUE;
            busy_d    = BUSY_AT_RESET;
         end
      endcase
   end

   // State, counter, pattern and status registers
   always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
         state_q   <= ST_INIT;
         counter_q <= '0;
         fill_q    <= RESET_FILL_VALUE;
         busy_q    <= BUSY_AT_RESET;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         fill_q    <= fill_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Port-B mux: sequencer owns the port only while filling
   always_comb begin
      if (state_q == ST_FILL) begin
         ram_wren_b    = 1'b1;
         ram_address_b = counter_q;
         ram_data_b    = fill_q;
      end else begin
         ram_wren_b    = 1'b0;
         ram_address_b = vga_address;
         ram_data_b    = '0;
      end
   end

   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;

endmodule

// File: doc/screen_ram_filler.md
Name: screen_ram_filler

Overview:
- Owns port B of the dual-port screen RAM and writes a fill pattern into every word.
- Sequences one word per CLK_50 cycle, either after reset release or on request.
- While idle, passes the VGA read address straight through, so the VGA scan-out keeps port B.
- Replaces the crude "write zero while reset is held" scheme with a complete, deterministic clear, and raises a hold request that keeps the CPU off the screen RAM while clearing.

Parameters:
- DATA_WIDTH, 16: RAM word width in bits.
- RAM_REGISTER_COUNT, 1024: number of RAM words; must be a power of 2, at least 2.
- ADDR_WIDTH, $clog2(RAM_REGISTER_COUNT): port-B address width (derived; do not override).
- FILL_ON_RESET, 1: 1 = start a fill automatically after reset release; 0 = wait for `start`.
- RESET_FILL_VALUE, 0: DATA_WIDTH pattern used by the automatic post-reset fill.

Ports:
- CLK_50  input  1  single clock; all state is clocked on its rising edge.
- resetN  input  1  reset, asynchronous, active-low.
- start  input  1  request a fill; sampled on the rising edge.
- fill_value  input  DATA_WIDTH  pattern for a `start` fill; latched when `start` is accepted.
- vga_address  input  ADDR_WIDTH  VGA read address, used while idle.
- ram_address_b  output  ADDR_WIDTH  port-B address.
- ram_data_b  output  DATA_WIDTH  port-B write data.
- ram_wren_b  output  1  port-B write enable.
- busy  output  1  fill in progress, or pending after reset.
- done  output  1  one-cycle pulse after the final word of a fill is written.
- cpu_hold  output  1  equals `busy`; gates the CPU clock enable.

Behaviour:
State machine:
- States: INIT, FILL, IDLE.
- `resetN` low: state = INIT, counter = 0, fill register = RESET_FILL_VALUE, done = 0.

Transitions:
- INIT -> FILL on the first edge after release if FILL_ON_RESET = 1; otherwise INIT -> IDLE.
- IDLE -> FILL on an edge with `start` = 1:
  - latch fill_value;
  - clear counter to 0.
- FILL:
  - each edge writes word[counter] = fill register, then increments counter;
  - on the edge writing counter = RAM_REGISTER_COUNT-1: go to IDLE, counter wraps to 0, done = 1 for exactly the next cycle.

Outputs:
- All outputs are Moore; `busy` and `cpu_hold` are registered.
- INIT: busy = cpu_hold = FILL_ON_RESET, ram_wren_b = 0, ram_address_b = vga_address, ram_data_b = 0.
- FILL:
  - ram_address_b = counter, ram_data_b = fill register, ram_wren_b = 1;
  - busy = cpu_hold = 1.
- IDLE: ram_address_b = vga_address, ram_data_b = 0, ram_wren_b = 0, busy = cpu_hold = 0.

Latency:
- A fill of N = RAM_REGISTER_COUNT words takes exactly N cycles with wren high.
- busy rises on the edge that accepts start (or at reset when FILL_ON_RESET = 1).
- busy falls on the same edge that raises done.

Boundary conditions:
- `start` while in FILL or INIT: ignored, no restart, fill value unchanged.
- `start` held continuously:
  - a new fill begins on the first IDLE edge, i.e. the cycle done is high;
  - done and the new busy then coincide for that cycle, and busy stays 1.
- Reset mid-fill:
  - wren, busy and done drop asynchronously and immediately (FILL_ON_RESET = 0) or hold-state (FILL_ON_RESET = 1, busy stays 1, wren 0);
  - after release, the fill restarts from address 0 with RESET_FILL_VALUE;
  - no partial-address resume.
- Counter is ADDR_WIDTH bits with natural wrap; there is no out-of-range address.
- `vga_address` changes during FILL have no effect; VGA reads stale or filled data during that time.
- fill_value changes during FILL have no effect.

Test Plan:
- Reset release, defaults (N = 1024): wren high for exactly 1024 cycles; addresses 0..1023 in order, data 16'h0000; done high one cycle on the edge after address 1023 is written; busy low from that edge.
- In IDLE, pulse start with fill_value = 16'hA5A5, then change fill_value to 16'h1234 mid-fill: all 1024 words read back 16'hA5A5.
- start re-asserted at fill address 500: no restart, total wren cycles = 1024, done exactly once.
- resetN low for 3 cycles at address 300: wren = 0 asynchronously within the cycle; after release a full 1024-word fill from address 0 with 16'h0000.
- IDLE with vga_address sweeping 0..1023: ram_address_b tracks it combinationally, wren = 0, busy = cpu_hold = 0.
- FILL_ON_RESET = 0: after reset release busy = 0 and no writes occur until start; start with 16'hFFFF fills all words with 16'hFFFF.
